// File: rtl/exc_commit_ctrl.sv
// Exception/ERTN commit controller: picks the winning cause from the WB stage,
// pulses the CSR file once, then flushes and redirects fetch with a handshake.
module exc_commit_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_vaddr,
  input  logic        wb_exc_adef,
  input  logic        wb_exc_ine,
  input  logic        wb_exc_sys,
  input  logic        wb_exc_brk,
  input  logic        wb_exc_ale,
  input  logic        wb_ertn,
  input  logic        has_int,
  input  logic [31:0] ex_entry,
  input  logic [31:0] ertn_entry,
  output logic        wb_ex,
  output logic        ertn_flush,
  output logic [5:0]  csr_ecode,
  output logic [8:0]  csr_esubcode,
  output logic [31:0] csr_pc,
  output logic [31:0] csr_vaddr,
  output logic        flush_all,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
);

  localparam logic [5:0] ECODE_INT = 6'h00;
  localparam logic [5:0] ECODE_ADE = 6'h08;
  localparam logic [5:0] ECODE_ALE = 6'h09;
  localparam logic [5:0] ECODE_SYS = 6'h0B;
  localparam logic [5:0] ECODE_BRK = 6'h0C;
  localparam logic [5:0] ECODE_INE = 6'h0D;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } state_e;

  state_e      state_q;
  logic        is_trap_q;
  logic        wb_ex_q;
  logic        ertn_flush_q;
  logic        flush_all_q;
  logic        redirect_valid_q;
  logic [31:0] redirect_pc_q;
  logic [5:0]  csr_ecode_q;
  logic [8:0]  csr_esubcode_q;
  logic [31:0] csr_pc_q;
  logic [31:0] csr_vaddr_q;

  logic        trap_s;
  logic [5:0]  ecode_d;
  logic [8:0]  esubcode_d;
  logic [31:0] vaddr_d;

  // Priority decode of the WB-stage cause: INT > ADEF > INE > SYS > BRK > ALE.
  always_comb begin
    trap_s     = has_int | wb_exc_adef | wb_exc_ine | wb_exc_sys | wb_exc_brk | wb_exc_ale;
    ecode_d    = ECODE_INT;
    esubcode_d = 9'd0;
    vaddr_d    = 32'h0000_0000;
    if (has_int) begin
      ecode_d = ECODE_INT;
    end else if (wb_exc_adef) begin
      ecode_d = ECODE_ADE;
      vaddr_d = wb_pc;
    end else if (wb_exc_ine) begin
      ecode_d = ECODE_INE;
    end else if (wb_exc_sys) begin
      ecode_d = ECODE_SYS;
    end else if (wb_exc_brk) begin
      ecode_d = ECODE_BRK;
    end else if (wb_exc_ale) begin
      ecode_d = ECODE_ALE;
      vaddr_d = wb_vaddr;
    end else begin
      ecode_d = ECODE_INT;
    end
  end

  // Commit FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      is_trap_q        <= 1'b0;
      wb_ex_q          <= 1'b0;
      ertn_flush_q     <= 1'b0;
      flush_all_q      <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'h0000_0000;
      csr_ecode_q      <= 6'h00;
      csr_esubcode_q   <= 9'd0;
      csr_pc_q         <= 32'h0000_0000;
      csr_vaddr_q      <= 32'h0000_0000;
    end else begin
      case (state_q)
        IDLE: begin
          if (wb_valid && (trap_s || wb_ertn)) begin
            state_q      <= FLUSH;
            is_trap_q    <= trap_s;
            wb_ex_q      <= trap_s;
            ertn_flush_q <= ~trap_s;
            flush_all_q  <= 1'b1;
            // CSR cause fields only change for traps; ERTN leaves them as they were.
            if (trap_s) begin
              csr_ecode_q    <= ecode_d;
              csr_esubcode_q <= esubcode_d;
              csr_pc_q       <= wb_pc;
              csr_vaddr_q    <= vaddr_d;
            end
          end
        end
        FLUSH: begin
          state_q          <= REDIRECT;
          wb_ex_q          <= 1'b0;
          ertn_flush_q     <= 1'b0;
          redirect_valid_q <= 1'b1;
          redirect_pc_q    <= is_trap_q ? ex_entry : ertn_entry;
        end
        REDIRECT: begin
          if (redirect_ready) begin
            state_q          <= IDLE;
            redirect_valid_q <= 1'b0;
            flush_all_q      <= 1'b0;
          end
        end
        default: begin
          state_q          <= IDLE;
          wb_ex_q          <= 1'b0;
          ertn_flush_q     <= 1'b0;
          flush_all_q      <= 1'b0;
          redirect_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign wb_ready       = (state_q == IDLE);
  assign wb_ex          = wb_ex_q;
  assign ertn_flush     = ertn_flush_q;
  assign flush_all      = flush_all_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign csr_ecode      = csr_ecode_q;
  assign csr_esubcode   = csr_esubcode_q;
  assign csr_pc         = csr_pc_q;
  assign csr_vaddr      = csr_vaddr_q;

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Randomized bench for exc_commit_ctrl against a transaction-level model of
// cause priority and the flush/redirect timeline.
module tb_exc_commit_ctrl;
  logic        clk, reset;
  logic        wb_valid, wb_ready;
  logic [31:0] wb_pc, wb_vaddr;
  logic        wb_exc_adef, wb_exc_ine, wb_exc_sys, wb_exc_brk, wb_exc_ale, wb_ertn;
  logic        has_int;
  logic [31:0] ex_entry, ertn_entry;
  logic        wb_ex, ertn_flush;
  logic [5:0]  csr_ecode;
  logic [8:0]  csr_esubcode;
  logic [31:0] csr_pc, csr_vaddr;
  logic        flush_all, redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  int checks = 0;
  int errors = 0;
  logic [5:0]  e_ec;
  logic [31:0] e_pc, e_va;

  exc_commit_ctrl dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .wb_exc_adef(wb_exc_adef),
    .wb_exc_ine(wb_exc_ine), .wb_exc_sys(wb_exc_sys), .wb_exc_brk(wb_exc_brk),
    .wb_exc_ale(wb_exc_ale), .wb_ertn(wb_ertn), .has_int(has_int),
    .ex_entry(ex_entry), .ertn_entry(ertn_entry), .wb_ex(wb_ex),
    .ertn_flush(ertn_flush), .csr_ecode(csr_ecode), .csr_esubcode(csr_esubcode),
    .csr_pc(csr_pc), .csr_vaddr(csr_vaddr), .flush_all(flush_all),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Winner = first raised flag in priority order; ERTN only when nothing traps.
  function automatic void model(input logic intr, adef, ine, sys, brk, ale, ertn,
                                input logic [31:0] pc, va,
                                output logic trap, output logic ertn_ev,
                                output logic [5:0] ec, output logic [31:0] bad);
    logic [5:0] codes [6];
    logic       f [6];
    codes[0] = 6'h00; codes[1] = 6'h08; codes[2] = 6'h0D;
    codes[3] = 6'h0B; codes[4] = 6'h0C; codes[5] = 6'h09;
    f[0] = intr; f[1] = adef; f[2] = ine; f[3] = sys; f[4] = brk; f[5] = ale;
    trap = 1'b0; ec = 6'h00; bad = 32'h0;
    for (int i = 0; i < 6; i++) begin
      if (f[i] && !trap) begin
        trap = 1'b1;
        ec   = codes[i];
        bad  = (i == 1) ? pc : ((i == 5) ? va : 32'h0);
      end
    end
    ertn_ev = !trap && ertn;
  endfunction

  task automatic clear_wb();
    wb_valid = 1'b0; has_int = 1'b0; wb_ertn = 1'b0;
    {wb_exc_adef, wb_exc_ine, wb_exc_sys, wb_exc_brk, wb_exc_ale} = 5'b00000;
  endtask

  task automatic junk_wb();
    wb_valid = 1'($urandom); has_int = 1'($urandom); wb_ertn = 1'($urandom);
    {wb_exc_adef, wb_exc_ine, wb_exc_sys, wb_exc_brk, wb_exc_ale} = 5'($urandom);
    wb_pc = $urandom; wb_vaddr = $urandom;
  endtask

  task automatic check_csr_hold(input string tag);
    check_val({tag, "_ecode"}, 32'(csr_ecode), 32'(e_ec));
    check_val({tag, "_esub"}, 32'(csr_esubcode), 32'h0);
    check_val({tag, "_pc"}, csr_pc, e_pc);
    check_val({tag, "_vaddr"}, csr_vaddr, e_va);
  endtask

  // Presents one WB instruction at the next edge and checks the whole event timeline;
  // k = number of REDIRECT cycles with redirect_ready low before the handshake.
  task automatic run_event(input logic v, intr, adef, ine, sys, brk, ale, ertn,
                           input logic [31:0] pc, va, xe, re, input int k);
    logic trap, eev;
    logic [5:0] ec;
    logic [31:0] bad, rpc;
    model(intr, adef, ine, sys, brk, ale, ertn, pc, va, trap, eev, ec, bad);
    wb_valid = v; has_int = intr; wb_exc_adef = adef; wb_exc_ine = ine;
    wb_exc_sys = sys; wb_exc_brk = brk; wb_exc_ale = ale; wb_ertn = ertn;
    wb_pc = pc; wb_vaddr = va; redirect_ready = 1'b0;
    check_val("ready_pre", 32'(wb_ready), 32'h1);
    @(posedge clk); #1;
    if (!(v && (trap || eev))) begin
      clear_wb();
      check_val("plain_outs", 32'({wb_ex, ertn_flush, flush_all, redirect_valid, wb_ready}), 32'h1);
      check_csr_hold("plain");
      return;
    end
    if (trap) begin
      e_ec = ec; e_pc = pc; e_va = bad;
    end
    check_val("flush_outs", 32'({wb_ex, ertn_flush, flush_all, redirect_valid, wb_ready}),
              32'({trap, !trap, 1'b1, 1'b0, 1'b0}));
    check_csr_hold("flush");
    junk_wb();
    ex_entry = xe; ertn_entry = re;
    rpc = trap ? xe : re;
    for (int j = 0; j <= k; j++) begin
      @(posedge clk); #1;
      check_val("redir_outs", 32'({wb_ex, ertn_flush, flush_all, redirect_valid, wb_ready}), 32'h06);
      check_val("redir_pc", redirect_pc, rpc);
      check_val("redir_ecode", 32'(csr_ecode), 32'(e_ec));
      ex_entry = $urandom; ertn_entry = $urandom;
      redirect_ready = (j == k);
      junk_wb();
    end
    @(posedge clk); #1;
    check_val("idle_outs", 32'({wb_ex, ertn_flush, flush_all, redirect_valid, wb_ready}), 32'h01);
    check_csr_hold("idle");
    clear_wb();
    redirect_ready = 1'b0;
  endtask

  initial begin
    clk = 1'b0; reset = 1'b1; clear_wb();
    wb_pc = 32'h0; wb_vaddr = 32'h0; ex_entry = 32'h0; ertn_entry = 32'h0;
    redirect_ready = 1'b0;
    e_ec = 6'h00; e_pc = 32'h0; e_va = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_outs", 32'({wb_ex, ertn_flush, flush_all, redirect_valid, wb_ready}), 32'h01);
    check_val("rst_rpc", redirect_pc, 32'h0);
    check_csr_hold("rst");
    reset = 1'b0;

    // Syscall, immediate handshake: IDLE again at T+3.
    run_event(1, 0, 0, 0, 1, 0, 0, 0, 32'h1c000100, 32'h0, 32'h1c008000, 32'h0, 0);
    // INT beats ADEF and ALE; then ADEF beats ALE.
    run_event(1, 1, 1, 0, 0, 0, 1, 0, 32'h1c000200, 32'h00002000, 32'h1c008000, 32'h0, 1);
    run_event(1, 0, 1, 0, 0, 0, 1, 0, 32'h1c000204, 32'h00002000, 32'h1c008000, 32'h0, 0);
    // ALE carries the data address.
    run_event(1, 0, 0, 0, 0, 0, 1, 0, 32'h1c000208, 32'h00001003, 32'h1c008000, 32'h0, 0);
    // ERTN with fetch stalled for 5 cycles; a trap together with ERTN wins.
    run_event(1, 0, 0, 0, 0, 0, 0, 1, 32'h1c00020c, 32'h0, 32'h1c008000, 32'h1c000204, 5);
    run_event(1, 0, 0, 0, 0, 1, 0, 1, 32'h1c000210, 32'h0, 32'h1c008000, 32'h1c000204, 0);

    // Pending interrupt waits for an instruction.
    for (int i = 0; i < 4; i++) begin
      wb_valid = 1'b0; has_int = 1'b1;
      @(posedge clk); #1;
      check_val("int_wait", 32'({wb_ex, ertn_flush, flush_all, redirect_valid, wb_ready}), 32'h01);
    end
    run_event(1, 1, 0, 0, 0, 0, 0, 0, 32'h1c000300, 32'h0, 32'h1c008000, 32'h0, 0);

    // Reset while in REDIRECT drops the event.
    wb_valid = 1'b1; wb_exc_sys = 1'b1; wb_pc = 32'h1c000400; ex_entry = 32'h1c008000;
    @(posedge clk); #1;
    clear_wb();
    @(posedge clk); #1;
    check_val("pre_rst_rv", 32'(redirect_valid), 32'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    e_ec = 6'h00; e_pc = 32'h0; e_va = 32'h0;
    check_val("rst2_outs", 32'({wb_ex, ertn_flush, flush_all, redirect_valid, wb_ready}), 32'h01);
    check_csr_hold("rst2");
    for (int i = 0; i < 3; i++) begin
      redirect_ready = 1'b1;
      @(posedge clk); #1;
      check_val("rst2_quiet", 32'({wb_ex, ertn_flush, flush_all, redirect_valid, wb_ready}), 32'h01);
    end
    redirect_ready = 1'b0;

    // Randomized mix of plain, trap and ERTN instructions.
    for (int n = 0; n < 60; n++) begin
      logic v, a, b, c, d, e, f, g;
      v = ($urandom_range(0, 7) != 0);
      a = ($urandom_range(0, 7) == 0);
      b = ($urandom_range(0, 5) == 0);
      c = ($urandom_range(0, 5) == 0);
      d = ($urandom_range(0, 5) == 0);
      e = ($urandom_range(0, 5) == 0);
      f = ($urandom_range(0, 5) == 0);
      g = ($urandom_range(0, 3) == 0);
      run_event(v, a, b, c, d, e, f, g, $urandom, $urandom, $urandom, $urandom,
                int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
